// File: rtl/im_pkg.sv
// Shared definitions for the instruction-store fetch/load controller.
package im_pkg;

  localparam int IM_ADDR_W      = 10;
  localparam int IM_DEPTH       = 1024;
  localparam int BEAT_W         = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_ACK   = 2'd3
  } im_state_e;

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// Bundle of loader, fetch and byte-store signals around im_fetch_ctrl.
interface im_fetch_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  import im_pkg::*;

  // Loader: a byte transfers on a rising edge where load_valid && load_ready;
  // load_valid/load_byte/load_last must hold until that edge.
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              loaded;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_instr;
  logic              fetch_err;

  logic              busy;
  im_state_e         state_dbg;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  load_start, load_valid, load_byte, load_last,
    input  fetch_req, fetch_addr, mem_rdata,
    output load_ready, load_done, load_count, loaded,
    output fetch_ack, fetch_instr, fetch_err,
    output busy, state_dbg, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output load_start, load_valid, load_byte, load_last,
    output fetch_req, fetch_addr, mem_rdata,
    input  load_ready, load_done, load_count, loaded,
    input  fetch_ack, fetch_instr, fetch_err,
    input  busy, state_dbg, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/im_word_assembler.sv
// Builds a 32-bit word from bytes, first byte ending up in bits [31:24].
module im_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] dout
);

  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clr) begin
      shreg_d = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[23:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign dout = shreg_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Arbitrates the single byte port of the instruction store between the
// program loader and 4-beat big-endian instruction fetches.
module im_fetch_ctrl
  import im_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DEPTH  = IM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  im_fetch_ctrl_if.slave  bus
);

  im_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               loaded_q, loaded_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;
  logic               ferr_q, ferr_d;
  logic [31:0]        instr_q, instr_d;

  logic               load_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_wdata;
  logic               asm_clr;
  logic               asm_shift;
  logic [31:0]        shreg;

  im_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .shift_en (asm_shift),
    .din      (bus.mem_rdata),
    .dout     (shreg)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    done_d     = 1'b0;
    addr_d     = addr_q;
    beat_d     = beat_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    ferr_d     = 1'b0;
    instr_d    = instr_q;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    asm_clr    = 1'b0;
    asm_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_d  = ST_LOAD;
          ptr_d    = '0;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end else if (bus.fetch_req && loaded_q) begin
          // Clearing here makes a misaligned ack return an all-zero word.
          addr_d  = bus.fetch_addr;
          beat_d  = '0;
          asm_clr = 1'b1;
          if (bus.fetch_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            err_d   = 1'b0;
            state_d = ST_FETCH;
          end
        end
      end

      ST_LOAD: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ptr_q;
          mem_wdata = bus.load_byte;
          ptr_d     = ptr_q + ADDR_W'(1);
          cnt_d     = cnt_q + (ADDR_W+1)'(1);
          if (bus.load_last || ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            loaded_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        mem_addr  = addr_q + ADDR_W'(beat_q);
        asm_shift = 1'b1;
        beat_d    = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BYTES_PER_WORD - 1)) begin
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        ack_d   = 1'b1;
        ferr_d  = err_q;
        instr_d = shreg;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      ferr_q   <= 1'b0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      ferr_q   <= ferr_d;
      instr_q  <= instr_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.load_done   = done_q;
  assign bus.load_count  = cnt_q;
  assign bus.loaded      = loaded_q;
  assign bus.fetch_ack   = ack_q;
  assign bus.fetch_instr = instr_q;
  assign bus.fetch_err   = ferr_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.state_dbg   = state_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_we      = mem_we;
  assign bus.mem_wdata   = mem_wdata;

endmodule
